// File: rtl/hilo_ctrl_pkg.sv
// Shared opcodes, engine encodings, FSM state type and defaults for the
// HI/LO multiply/divide controller.
package hilo_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam int TIMEOUT_CYC_DEFAULT = 63;
    localparam int TIMER_W             = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Instruction opcode to engine opcode; non-engine ops map to MD_MULT.
    function automatic logic [1:0] md_op_of(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            OP_MULTU: r = MD_MULTU;
            OP_DIV:   r = MD_DIV;
            OP_DIVU:  r = MD_DIVU;
            default:  r = MD_MULT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register file and sequencing controller that issues MULT/DIV
// operations to an external engine and serves MFHI/MFLO/MTHI/MTLO.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        dz,
    output logic        timeout,
    output logic [1:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_start,
    input  logic        md_busy,
    input  logic        md_write,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo
);

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_next;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [TIMER_W-1:0] timer;

    logic is_md_op;
    logic is_div;
    logic idle;
    logic accept;
    logic div_zero;
    logic start_op;
    logic result_in;
    logic timer_expire;

    // Decode, stall and acceptance; an op is consumed only in IDLE without stall.
    always_comb begin
        is_md_op     = ~op_code[2];
        is_div       = is_md_op & op_code[1];
        idle         = (state == ST_IDLE);
        stall        = op_valid & (~idle | (is_md_op & md_busy));
        accept       = op_valid & ~stall;
        div_zero     = accept & is_div & (rt_data == '0);
        start_op     = accept & is_md_op & ~div_zero;
        result_in    = (state == ST_WAIT) & md_write;
        timer_expire = (state == ST_WAIT) & ~md_write & (timer == TMO_LAST);
        md_start     = (state == ST_ISSUE);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_op) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (result_in || timer_expire) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Results are served only from IDLE; a completing WAIT cycle still stalls.
    always_comb begin
        rd_data = '0;
        if (accept && op_code == OP_MFHI) begin
            rd_data = hi;
        end else if (accept && op_code == OP_MFLO) begin
            rd_data = lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_op <= MD_MULT;
            md_a  <= '0;
            md_b  <= '0;
        end else if (start_op) begin
            md_op <= md_op_of(op_code);
            md_a  <= rs_data;
            md_b  <= rt_data;
        end
    end

    // Engine writes are only honoured in WAIT, so a reset or timeout drops late results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (result_in) begin
            hi <= md_hi;
            lo <= md_lo;
        end else if (accept && op_code == OP_MTHI) begin
            hi <= rs_data;
        end else if (accept && op_code == OP_MTLO) begin
            lo <= rs_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ST_ISSUE) begin
            timer <= '0;
        end else if (state == ST_WAIT && !md_write && timer != TMO_LAST) begin
            timer <= timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz      <= 1'b0;
            timeout <= 1'b0;
        end else begin
            dz      <= div_zero;
            timeout <= timer_expire;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl with a small fixed-latency
// multiply/divide engine model.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    localparam int ENG_LAT   = 4;
    localparam int MAX_STALL = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall;
    logic [31:0] rd_data;
    logic        dz;
    logic        timeout;
    logic [1:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_start;
    logic        md_busy;
    logic        md_write = 1'b0;
    logic [31:0] md_hi = '0;
    logic [31:0] md_lo = '0;

    logic        engBusy = 1'b0;
    bit          forceBusy = 1'b0;
    bit          engEnable = 1'b1;
    int          engCnt = 0;
    logic [63:0] engRes = '0;
    int          startCount = 0;

    int checkCount = 0;
    int failCount  = 0;
    int n;
    int s0;

    hilo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .rd_data  (rd_data),
        .dz       (dz),
        .timeout  (timeout),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_start (md_start),
        .md_busy  (md_busy),
        .md_write (md_write),
        .md_hi    (md_hi),
        .md_lo    (md_lo)
    );

    always #5 clk = ~clk;

    assign md_busy = engBusy | forceBusy;

    // Reference arithmetic for the engine model: {HI, LO}.
    function automatic logic [63:0] engResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        logic [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        r  = '0;
        case (op)
            2'd0: r = sa * sb;
            2'd1: r = {32'b0, a} * {32'b0, b};
            2'd2: if (b != 0) r = {qa % qb, qa / qb};
            default: if (b != 0) r = {a % b, a / b};
        endcase
        return r;
    endfunction

    // Engine: busy for ENG_LAT cycles after seeing md_start, then one md_write pulse.
    always @(posedge clk) begin
        md_write <= 1'b0;
        if (md_start) begin
            startCount <= startCount + 1;
            engCnt     <= ENG_LAT;
            engBusy    <= 1'b1;
            engRes     <= engResult(md_op, md_a, md_b);
        end else if (engCnt > 1) begin
            engCnt <= engCnt - 1;
        end else if (engCnt == 1) begin
            engCnt  <= 0;
            engBusy <= 1'b0;
            if (engEnable) begin
                md_write <= 1'b1;
                md_hi    <= engRes[63:32];
                md_lo    <= engRes[31:0];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt);
        op_valid = v;
        op_code  = op;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge with the op held; returns at the negedge of the serving cycle.
    task automatic waitServe(output int cnt);
        cnt = 0;
        while (stall && cnt < MAX_STALL) begin
            cnt++;
            tick();
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, OP_MULT, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_md_start", {31'b0, md_start}, 32'h0);
        checkOutput("rst_md_op", {30'b0, md_op}, 32'h0);
        checkOutput("rst_md_a", md_a, 32'h0);
        checkOutput("rst_md_b", md_b, 32'h0);
        checkOutput("rst_dz_timeout", {30'b0, dz, timeout}, 32'h0);

        // MULTU accepted on the first cycle after reset, MFHI stalls until result.
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        @(negedge clk);
        checkOutput("multu_accept_stall", {31'b0, stall}, 32'h0);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("multu_md_start", {31'b0, md_start}, 32'h1);
        checkOutput("multu_md_op", {30'b0, md_op}, 32'h1);
        checkOutput("multu_md_a", md_a, 32'hFFFF_FFFF);
        checkOutput("multu_md_b", md_b, 32'h2);
        waitServe(n);
        checkOutput("multu_stalls", n, 32'd6);
        checkOutput("multu_hi", rd_data, 32'h0000_0001);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("multu_lo", rd_data, 32'hFFFF_FFFE);
        checkOutput("multu_starts", startCount, 32'd1);

        // DIVU 7/2
        tick();
        applyStimulus(1'b1, OP_DIVU, 32'd7, 32'd2);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("divu_md_op", {30'b0, md_op}, 32'h3);
        waitServe(n);
        checkOutput("divu_stalls", n, 32'd6);
        checkOutput("divu_lo", rd_data, 32'd3);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("divu_hi", rd_data, 32'd1);

        // Divide by zero keeps HI/LO from MTHI/MTLO
        tick();
        applyStimulus(1'b1, OP_MTHI, 32'hAAAA_0000, 32'h0);
        tick();
        applyStimulus(1'b1, OP_MTLO, 32'h0000_5555, 32'h0);
        tick();
        s0 = startCount;
        applyStimulus(1'b1, OP_DIV, 32'd5, 32'd0);
        @(negedge clk);
        checkOutput("dz_accept_stall", {31'b0, stall}, 32'h0);
        checkOutput("dz_not_yet", {31'b0, dz}, 32'h0);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("dz_pulse", {31'b0, dz}, 32'h1);
        checkOutput("dz_no_start", {31'b0, md_start}, 32'h0);
        checkOutput("dz_idle_stall", {31'b0, stall}, 32'h0);
        checkOutput("dz_hi_kept", rd_data, 32'hAAAA_0000);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("dz_pulse_end", {31'b0, dz}, 32'h0);
        checkOutput("dz_lo_kept", rd_data, 32'h0000_5555);
        checkOutput("dz_start_count", startCount, s0);

        // Signed MULT -2*3 and DIV -7/2
        tick();
        applyStimulus(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        waitServe(n);
        checkOutput("mult_hi", rd_data, 32'hFFFF_FFFF);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mult_lo", rd_data, 32'hFFFF_FFFA);
        tick();
        applyStimulus(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        waitServe(n);
        checkOutput("div_lo", rd_data, 32'hFFFF_FFFD);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("div_hi", rd_data, 32'hFFFF_FFFF);

        // MTHI presented during WAIT overwrites the engine HI once accepted
        tick();
        applyStimulus(1'b1, OP_MULT, 32'd3, 32'd5);
        tick();
        applyStimulus(1'b1, OP_MTHI, 32'h1234_5678, 32'h0);
        @(negedge clk);
        checkOutput("mthi_wait_stall", {31'b0, stall}, 32'h1);
        waitServe(n);
        checkOutput("mthi_wait_stalls", n, 32'd6);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mthi_hi", rd_data, 32'h1234_5678);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mthi_lo", rd_data, 32'd15);

        // Engine busy in IDLE blocks issue but not MFHI
        tick();
        forceBusy = 1'b1;
        applyStimulus(1'b1, OP_MULTU, 32'd1, 32'd1);
        @(negedge clk);
        checkOutput("busy_stall", {31'b0, stall}, 32'h1);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("busy_no_issue", {31'b0, md_start}, 32'h0);
        checkOutput("busy_mfhi_stall", {31'b0, stall}, 32'h0);
        tick();
        forceBusy = 1'b0;
        applyStimulus(1'b1, OP_MULTU, 32'd1, 32'd1);
        @(negedge clk);
        checkOutput("busy_release", {31'b0, stall}, 32'h0);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("busy_issue", {31'b0, md_start}, 32'h1);
        waitServe(n);
        checkOutput("busy_lo", rd_data, 32'd1);

        // Engine never writes: timeout after 63 WAIT cycles
        tick();
        applyStimulus(1'b1, OP_MTHI, 32'hCAFE_0001, 32'h0);
        tick();
        engEnable = 1'b0;
        applyStimulus(1'b1, OP_MULTU, 32'd9, 32'd9);
        tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        waitServe(n);
        checkOutput("tmo_stalls", n, 32'd64);
        checkOutput("tmo_pulse", {31'b0, timeout}, 32'h1);
        checkOutput("tmo_hi_kept", rd_data, 32'hCAFE_0001);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("tmo_pulse_end", {31'b0, timeout}, 32'h0);
        checkOutput("tmo_lo_kept", rd_data, 32'd1);
        tick();
        engEnable = 1'b1;
        applyStimulus(1'b0, OP_MULT, 32'h0, 32'h0);
        repeat (6) tick();

        // Reset during WAIT; the late engine write must be ignored
        applyStimulus(1'b1, OP_MULTU, 32'hDEAD_0000, 32'h0001_0000);
        tick();
        applyStimulus(1'b0, OP_MULT, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_wait_md_a", md_a, 32'h0);
        checkOutput("rst_wait_start", {31'b0, md_start}, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst_first_stall", {31'b0, stall}, 32'h0);
        checkOutput("rst_hi_cleared", rd_data, 32'h0);
        tick();
        applyStimulus(1'b0, OP_MULT, 32'h0, 32'h0);
        repeat (3) tick();
        applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("late_write_hi", rd_data, 32'h0);
        checkOutput("late_write_stall", {31'b0, stall}, 32'h0);
        tick();
        applyStimulus(1'b1, OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("late_write_lo", rd_data, 32'h0);
        tick();
        applyStimulus(1'b0, OP_MULT, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("idle_rd_zero", rd_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
